// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Brief    : Fetch-unit bus bundle: imem req/gnt/rvalid, decoder valid/ready,
//            redirect and halt status.
// Revision : 1.0
// ============================================================================
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [5:0]        opcode;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, halted,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, halted,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Credit-limited instruction prefetcher with in-order FIFO, PC
//            redirect/flush. Optional FETCH_HALT_ON_ILLEGAL_EN stops on bad opcode.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2,
    parameter int                PC_STEP    = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    instr_fetch_if.master bus
);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
`ifdef FETCH_HALT_ON_ILLEGAL_EN
    localparam logic [1:0] c_HALT = 2'd2;
`endif

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [c_CW-1:0]   r_outst;
    logic [c_CW-1:0]   r_drop;
    logic [c_CW-1:0]   r_count;
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [31:0]       r_mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [FIFO_DEPTH];

    logic              w_fifo_ne;
    logic              w_credit;
    logic              w_halt;
    logic              w_req;
    logic              w_gnt;
    logic              w_rv;
    logic              w_drop_rv;
    logic              w_push;
    logic              w_valid;
    logic              w_pop;
    logic [c_CW-1:0]   w_outst_nxt;
    logic [31:0]       w_head;
    logic [31:0]       w_instr;

    assign w_fifo_ne = (r_count != '0);
    assign w_head    = r_mem_data[r_rd_ptr];
    // Words already in flight also occupy a future FIFO slot.
    assign w_credit  = ({1'b0, r_outst} + {1'b0, r_count}) < (c_CW+1)'(FIFO_DEPTH);

`ifdef FETCH_HALT_ON_ILLEGAL_EN
    logic w_illegal;
    always_comb begin
        case (w_head[31:26])
            6'b000000, 6'b100011, 6'b101011, 6'b001000: w_illegal = 1'b0;
            default:                                   w_illegal = 1'b1;
        endcase
    end
    assign w_halt = (r_state == c_HALT) || ((r_state == c_RUN) && w_fifo_ne && w_illegal);
`else
    assign w_halt = 1'b0;
`endif

    assign w_req       = (r_state == c_RUN) && w_credit && !w_halt;
    assign w_gnt       = w_req && bus.imem_gnt;
    assign w_rv        = bus.imem_rvalid && (r_outst != '0);
    assign w_drop_rv   = w_rv && (r_drop != '0);
    assign w_push      = w_rv && !w_drop_rv && !bus.redirect && !w_halt;
    assign w_valid     = w_fifo_ne && !w_halt;
    assign w_pop       = w_valid && bus.instr_ready;
    assign w_outst_nxt = r_outst + c_CW'(w_gnt) - c_CW'(w_rv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_outst  <= '0;
            r_drop   <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (bus.redirect) begin
                // Everything still in flight after this cycle belongs to the old stream.
                r_state  <= c_RUN;
                r_pc     <= bus.redirect_pc;
                r_rsp_pc <= bus.redirect_pc;
                r_drop   <= w_outst_nxt;
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (r_state == c_IDLE) begin
                    r_state <= c_RUN;
                end
`ifdef FETCH_HALT_ON_ILLEGAL_EN
                if (w_halt && (r_state == c_RUN)) begin
                    r_state <= c_HALT;
                    r_drop  <= w_outst_nxt;
                end else if (w_drop_rv) begin
                    r_drop <= r_drop - c_CW'(1);
                end
`else
                if (w_drop_rv) begin
                    r_drop <= r_drop - c_CW'(1);
                end
`endif
                if (w_gnt) begin
                    r_pc <= r_pc + ADDR_W'(PC_STEP);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + ADDR_W'(PC_STEP);
                    r_wr_ptr <= r_wr_ptr + c_PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PW'(1);
                end
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus.imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    assign w_instr         = w_valid ? w_head : '0;
    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = w_instr;
    assign bus.instr_pc    = w_valid ? r_mem_pc[r_rd_ptr] : '0;
    assign bus.opcode      = w_instr[31:26];
    assign bus.halted      = w_halt;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit with an
//            in-order imem responder model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2),
        .PC_STEP    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pres_pc[$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_err    = 0;
    bit          gnt_rand;
    bit          lat_rand;
    bit          w8_ill;
    bit          found;
    int          lat;
    int          n8;
    logic [31:0] exp_pc;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C01_0000;
        if (a == 32'h4) return 32'h2002_0005;
        if (a == 32'h8 && w8_ill) return 32'hFC00_0000;
        return {6'b0, a[25:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input int idx, input int which);
        if (which == 0) return (gnt_log.size() > idx) ? gnt_log[idx] : 32'hDEAD_BEEF;
        return (pres_pc.size() > idx) ? pres_pc[idx] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk_rst_outputs();
        chk("rst_req",    32'(bus.imem_req),    32'h0);
        chk("rst_addr",   bus.imem_addr,        32'h0);
        chk("rst_valid",  32'(bus.instr_valid), 32'h0);
        chk("rst_instr",  bus.instr,            32'h0);
        chk("rst_pc",     bus.instr_pc,         32'h0);
        chk("rst_opcode", 32'(bus.opcode),      32'h0);
        chk("rst_halted", 32'(bus.halted),      32'h0);
    endtask

    // Called at a negedge; drives memory-side inputs, advances one clock, returns at next negedge.
    task automatic step();
        logic        acc;
        logic        rv;
        logic [31:0] acc_addr;
        logic [31:0] exp_w;
        bus.imem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        rv              = (q.size() > 0) && (q[0].due <= cyc);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? memword(q[0].addr) : 32'h0;
        #1;
        acc      = bus.imem_req && bus.imem_gnt;
        acc_addr = bus.imem_addr;
        if (bus.instr_valid && bus.instr_ready) begin
            exp_w = memword(exp_pc);
            chk("stream_pc",     bus.instr_pc,        exp_pc);
            chk("stream_instr",  bus.instr,           exp_w);
            chk("stream_opcode", 32'(bus.opcode),     32'(exp_w[31:26]));
            pres_pc.push_back(bus.instr_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (bus.redirect) exp_pc = bus.redirect_pc;
        @(posedge clk);
        cyc++;
        if (rv) void'(q.pop_front());
        if (acc) begin
            if (lat_rand) lat = int'($urandom_range(1, 5));
            q.push_back('{addr: acc_addr, due: cyc + lat - 1});
            gnt_log.push_back(acc_addr);
        end
        chk("outstanding_le_2", 32'(q.size() <= 2), 32'h1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        q.delete();
        gnt_log.delete();
        pres_pc.delete();
        exp_pc = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        gnt_rand = 1'b0;
        lat_rand = 1'b0;
        w8_ill   = 1'b0;
        lat      = 1;
        exp_pc   = 32'h0;

        // Reset values, then async reset with two requests in flight
        @(negedge clk);
        chk_rst_outputs();
        rst = 1'b0;
        lat = 3;
        bus.instr_ready = 1'b1;
        repeat (4) step();
        chk("t1_inflight", 32'(q.size()), 32'd2);
        chk("t1_gnt0", qget(0, 0), 32'h0);
        chk("t1_gnt1", qget(1, 0), 32'h4);
        #2 rst = 1'b1;
        #1 chk_rst_outputs();
        q.delete();
        gnt_log.delete();
        pres_pc.delete();
        bus.imem_rvalid = 1'b0;
        exp_pc = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        lat = 1;
        repeat (10) step();
        chk("t1_seq0", qget(0, 0), 32'h0);
        chk("t1_seq1", qget(1, 0), 32'h4);
        chk("t1_seq2", qget(2, 0), 32'h8);

        // Back-pressure fills the two credits and stalls requests
        do_reset();
        bus.instr_ready = 1'b0;
        repeat (8) step();
        chk("t2_ngnt",   32'(gnt_log.size()),   32'd2);
        chk("t2_req",    32'(bus.imem_req),     32'h0);
        chk("t2_valid",  32'(bus.instr_valid),  32'h1);
        chk("t2_pc0",    bus.instr_pc,          32'h0);
        chk("t2_instr0", bus.instr,             32'h8C01_0000);
        chk("t2_op0",    32'(bus.opcode),       32'h23);
        bus.instr_ready = 1'b1;
        step();
        chk("t2_pc1",    bus.instr_pc,          32'h4);
        chk("t2_instr1", bus.instr,             32'h2002_0005);
        chk("t2_op1",    32'(bus.opcode),       32'h08);
        repeat (4) step();
        chk("t2_pres0", qget(0, 1), 32'h0);
        chk("t2_pres1", qget(1, 1), 32'h4);

        // Redirect with two responses outstanding (latency 3)
        do_reset();
        lat = 3;
        repeat (3) step();
        chk("t3_inflight", 32'(q.size()), 32'd2);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        pres_pc.delete();
        repeat (20) step();
        chk("t3_first", qget(0, 1), 32'h40);
        chk("t3_second", qget(1, 1), 32'h44);

        // Redirect in the same cycle as the handshake of pc 0x8
        do_reset();
        lat   = 1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (bus.instr_valid && bus.instr_pc == 32'h8) begin
                found           = 1'b1;
                bus.redirect    = 1'b1;
                bus.redirect_pc = 32'h80;
            end
            step();
            bus.redirect = 1'b0;
        end
        chk("t4_found", 32'(found), 32'h1);
        n8 = 0;
        foreach (pres_pc[k]) if (pres_pc[k] == 32'h8) n8++;
        chk("t4_once", 32'(n8), 32'd1);
        pres_pc.delete();
        repeat (10) step();
        chk("t4_next", qget(0, 1), 32'h80);

        // Random grant/latency/ready with periodic redirects
        do_reset();
        gnt_rand = 1'b1;
        lat_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bus.instr_ready = 1'($urandom_range(0, 1));
            if (i % 150 == 149) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = 32'($urandom_range(0, 1023)) * 32'd4;
            end
            step();
            bus.redirect = 1'b0;
        end
        chk("t5_progress", 32'(pres_pc.size() > 20), 32'h1);
        gnt_rand = 1'b0;
        lat_rand = 1'b0;
        lat      = 1;

        // Unsupported opcode at 0x8
        do_reset();
        w8_ill = 1'b1;
        bus.instr_ready = 1'b1;
`ifdef FETCH_HALT_ON_ILLEGAL_EN
        repeat (15) step();
        chk("t6_halted", 32'(bus.halted),      32'h1);
        chk("t6_req",    32'(bus.imem_req),    32'h0);
        chk("t6_valid",  32'(bus.instr_valid), 32'h0);
        chk("t6_npres",  32'(pres_pc.size()),  32'd2);
        chk("t6_pres0",  qget(0, 1),           32'h0);
        chk("t6_pres1",  qget(1, 1),           32'h4);
        w8_ill          = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0;
        gnt_log.delete();
        step();
        bus.redirect = 1'b0;
        chk("t6_unhalt", 32'(bus.halted), 32'h0);
        repeat (5) step();
        chk("t6_resume", qget(0, 0), 32'h0);
`else
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.instr_valid && bus.instr_pc == 32'h8) begin
                found = 1'b1;
                chk("t6_opcode", 32'(bus.opcode), 32'h3F);
                chk("t6_instr",  bus.instr,       32'hFC00_0000);
                chk("t6_halted", 32'(bus.halted), 32'h0);
            end
            step();
        end
        chk("t6_found", 32'(found), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
